ps2_rx_fifo: RTL and testbench
==============================

Name: ps2_rx_fifo

Overview:
Parametrised PS/2 keyboard receiver that replaces the single-register scan-code latch in the glue CPLD. It synchronises and debounces the PS/2 lines, decodes full 11-bit frames (start, 8 data, odd parity, stop) and checks every field. Valid scan codes are pushed into a DEPTH-entry FIFO read by the Z180 through the CPLD I/O decode at 0x4000. Sticky error flags and a busy indicator are exposed for a status register and the U0 LED.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2
SAMPLE_DELAY, 8, CLK cycles KB_CLK must stay low after a falling edge before KB_DATA is sampled
SYNC_STAGES, 2, flip-flop stages on KB_CLK and KB_DATA; minimum 2
TIMEOUT_CYCLES, 4096, CLK cycles of KB_CLK high mid-frame before the frame is aborted (used only with the optional feature)

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  asynchronous active-low reset
KB_CLK  in  1  raw PS/2 clock (asynchronous)
KB_DATA  in  1  raw PS/2 data (asynchronous)
RD  in  1  one-cycle pop strobe from the I/O decode (read of 0x4000)
ERR_CLR  in  1  one-cycle strobe; clears sticky error flags
DOUT  out  8  FIFO head (first-word fall-through)
EMPTY  out  1  FIFO empty
FULL  out  1  FIFO full
COUNT  out  $clog2(DEPTH)+1  entries held
PERR  out  1  sticky parity error
FERR  out  1  sticky framing error (bad stop bit, or timeout)
OVF  out  1  sticky overflow (valid frame dropped because FIFO full)
BUSY  out  1  high while a frame is in progress (drives U0 LED)

Behaviour:
- Reset (RST low, async): FIFO pointers 0, DOUT 0x00, EMPTY 1, FULL 0, COUNT 0, PERR/FERR/OVF 0, BUSY 0, FSM IDLE, bit counter 0, delay counter 0, sync flops 1.
- Sync: both lines pass through SYNC_STAGES flops; falling edge = previous synced 1, current synced 0.
- Sampling: falling edge loads the delay counter. Sample is taken on the cycle the counter reaches SAMPLE_DELAY with synced KB_CLK still low; exactly one sample per low phase. If KB_CLK returns high first, the pulse is a glitch: no sample, FSM unchanged.
- FSM (advances only on a sample):
  IDLE: sample 0 -> DATA, BUSY=1, bit count 0; sample 1 -> stay IDLE (noise).
  DATA: shift in LSB first; after 8th bit -> PARITY.
  PARITY: store bit -> STOP.
  STOP: go IDLE, BUSY=0. Stop bit 0 -> FERR=1, discard. Odd parity fails (data+parity ones count even) -> PERR=1, discard. Both bad -> both flags set. Otherwise push.
- Push occurs the cycle after the stop sample. If full and no pop that cycle -> frame dropped, OVF=1, FIFO contents unchanged.
- Pop: RD high and not empty -> read pointer advances; DOUT shows the next entry the following cycle. RD while empty ignored; DOUT=0x00 whenever EMPTY.
- Push and pop in the same cycle: both succeed, COUNT unchanged, including when full.
- Pointers wrap modulo DEPTH. COUNT is exact 0..DEPTH. FULL = (COUNT==DEPTH).
- ERR_CLR clears PERR/FERR/OVF. A set event in the same cycle wins (flag stays 1).
- Only RST aborts a frame; no soft reset exists.

Optional Feature:
PS2_RX_TIMEOUT_EN: when defined, a counter runs while BUSY and synced KB_CLK is high. It resets on each falling edge. On reaching TIMEOUT_CYCLES the FSM returns to IDLE, BUSY=0, FERR=1, and the partial frame is discarded. When undefined, there is no counter, and a frame truncated mid-stream resynchronises only through the start-bit check or RST.

Test Plan:
- Frame 0x1C, parity 0, stop 1, 40 us half-period clocks -> EMPTY 1->0, COUNT=1, DOUT=0x1C, PERR=FERR=0; RD pulse -> EMPTY=1, DOUT=0x00.
- Frame 0x1C with parity 1 -> PERR=1, COUNT=0. ERR_CLR -> PERR=0. Then frame 0xF0 with stop 0 -> FERR=1, COUNT=0.
- DEPTH+1 (5) valid frames 0x01..0x05, no reads -> FULL=1, OVF=1, COUNT=4. Four RDs return 0x01,0x02,0x03,0x04.
- FIFO full; RD asserted on the push cycle of 0x06 -> COUNT stays 4, OVF stays 0, last entry 0x06.
- KB_CLK low glitch of SAMPLE_DELAY-2 cycles mid-frame -> no extra bit; following valid bits decode 0x5A correctly. Separately, RST low after 4 data bits -> all outputs at reset values; next full frame decodes correctly.
- With PS2_RX_TIMEOUT_EN: stop KB_CLK high after 3 data bits -> BUSY=0 and FERR=1 exactly TIMEOUT_CYCLES after the last falling edge; next frame 0x29 decodes correctly.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: sync/debounce, 11-bit frame decode with field checks, scan-code FIFO.
// Latency: push lands in the FIFO two cycles after the stop-bit sample; DOUT is first-word fall-through.
// Backpressure: none toward the keyboard; a valid frame arriving at a full FIFO with no pop is dropped and sets OVF.
// Optional build macro PS2_RX_TIMEOUT_EN adds a mid-frame KB_CLK-high timeout that aborts the frame.
module ps2_rx_fifo #(
    parameter int DEPTH          = 4,
    parameter int SAMPLE_DELAY   = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     KB_CLK,
    input  logic                     KB_DATA,
    input  logic                     RD,
    input  logic                     ERR_CLR,
    output logic [7:0]               DOUT,
    output logic                     EMPTY,
    output logic                     FULL,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     PERR,
    output logic                     FERR,
    output logic                     OVF,
    output logic                     BUSY
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(SAMPLE_DELAY + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    // ---------------- synchronisers ----------------
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
    logic                   clk_s, dat_s;

    // Shift raw lines through the synchroniser chains
    always_comb begin
        clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], KB_CLK};
        dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], KB_DATA};
    end

    // Synchroniser flops idle high like the bus
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
        end
    end

    assign clk_s = clk_sync_q[SYNC_STAGES-1];
    assign dat_s = dat_sync_q[SYNC_STAGES-1];

    // ---------------- falling edge + sample delay ----------------
    logic          clk_prev_q, clk_prev_d;
    logic [DW-1:0] dly_q, dly_d;
    logic          armed_q, armed_d;
    logic          clk_fall, sample;

    // Arm on a falling edge, count while low, fire once at SAMPLE_DELAY; a rising edge first cancels it as a glitch
    always_comb begin
        clk_prev_d = clk_s;
        clk_fall   = clk_prev_q & ~clk_s;
        sample     = armed_q & ~clk_s & (dly_q == DW'(SAMPLE_DELAY));
        dly_d      = dly_q;
        armed_d    = armed_q;
        if (clk_fall) begin
            dly_d   = DW'(1);
            armed_d = 1'b1;
        end else if (clk_s || sample) begin
            dly_d   = '0;
            armed_d = 1'b0;
        end else if (armed_q) begin
            dly_d   = dly_q + DW'(1);
        end
    end

    // Sampler state registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            clk_prev_q <= 1'b1;
            dly_q      <= '0;
            armed_q    <= 1'b0;
        end else begin
            clk_prev_q <= clk_prev_d;
            dly_q      <= dly_d;
            armed_q    <= armed_d;
        end
    end

    // ---------------- optional frame timeout ----------------
    logic busy_q;
    logic timeout;
`ifdef PS2_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_q, to_d;

    // Count KB_CLK-high cycles inside a frame; any falling edge restarts the count
    always_comb begin
        to_d    = to_q;
        timeout = 1'b0;
        if (!busy_q || clk_fall) begin
            to_d = '0;
        end else if (clk_s) begin
            if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
                timeout = 1'b1;
                to_d    = '0;
            end else begin
                to_d = to_q + TW'(1);
            end
        end
    end

    // Timeout counter register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) to_q <= '0;
        else      to_q <= to_d;
    end
`else
    // No timeout in this build; a truncated frame resyncs via the start-bit check or reset
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    // ---------------- frame FSM ----------------
    state_t     state_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] shreg_q;
    logic       par_q;
    logic       push_q;
    logic       perr_set_q;
    logic       ferr_set_q;

    // Frame decoder: advances only on samples; emits one-cycle push/error pulses after the stop bit
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            busy_q     <= 1'b0;
            push_q     <= 1'b0;
            perr_set_q <= 1'b0;
            ferr_set_q <= 1'b0;
        end else begin
            push_q     <= 1'b0;
            perr_set_q <= 1'b0;
            ferr_set_q <= 1'b0;
            if (timeout) begin
                state_q    <= S_IDLE;
                busy_q     <= 1'b0;
                ferr_set_q <= 1'b1;
            end else if (sample) begin
                case (state_q)
                    S_IDLE: begin
                        if (!dat_s) begin
                            state_q   <= S_DATA;
                            busy_q    <= 1'b1;
                            bit_cnt_q <= '0;
                        end
                    end
                    S_DATA: begin
                        shreg_q   <= {dat_s, shreg_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_q <= S_PARITY;
                    end
                    S_PARITY: begin
                        par_q   <= dat_s;
                        state_q <= S_STOP;
                    end
                    default: begin
                        state_q    <= S_IDLE;
                        busy_q     <= 1'b0;
                        ferr_set_q <= ~dat_s;
                        perr_set_q <= ~(^{shreg_q, par_q});
                        push_q     <= dat_s & (^{shreg_q, par_q});
                    end
                endcase
            end
        end
    end

    // ---------------- FIFO ----------------
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty, full, pop, push_ok, ovf_set;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign pop     = RD & ~empty;
    assign push_ok = push_q & (~full | pop);
    assign ovf_set = push_q & full & ~pop;

    // Pointer and occupancy update; simultaneous push/pop leaves COUNT unchanged
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_ok && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push_ok) count_d = count_q - CW'(1);
    end

    // FIFO pointer registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: DOUT is forced to zero while empty
    always_ff @(posedge CLK) begin
        if (push_ok) mem_q[wr_ptr_q] <= shreg_q;
    end

    // ---------------- sticky flags ----------------
    logic perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;

    // Clear strobe loses to a same-cycle set event
    always_comb begin
        perr_d = (perr_q & ~ERR_CLR) | perr_set_q;
        ferr_d = (ferr_q & ~ERR_CLR) | ferr_set_q;
        ovf_d  = (ovf_q  & ~ERR_CLR) | ovf_set;
    end

    // Sticky flag registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            perr_q <= perr_d;
            ferr_q <= ferr_d;
            ovf_q  <= ovf_d;
        end
    end

    assign DOUT  = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign EMPTY = empty;
    assign FULL  = full;
    assign COUNT = count_q;
    assign PERR  = perr_q;
    assign FERR  = ferr_q;
    assign OVF   = ovf_q;
    assign BUSY  = busy_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: queue-based reference model checked every settled cycle, plus literal spot checks.
// Latency: frames are bit-banged at 30-cycle half periods; model updates once each frame has settled.
// Backpressure: exercises full/overflow, push+pop on a full FIFO, glitches, mid-frame reset.
module tb_ps2_rx_fifo;
    localparam int DEPTH = 4;
    localparam int SD    = 8;
    localparam int SS    = 2;
    localparam int TO    = 4096;
    localparam int HALF  = 30;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       KB_CLK = 1'b1;
    logic       KB_DATA = 1'b1;
    logic       RD = 1'b0;
    logic       ERR_CLR = 1'b0;
    logic [7:0] DOUT;
    logic       EMPTY, FULL, PERR, FERR, OVF, BUSY;
    logic [2:0] COUNT;

    ps2_rx_fifo #(.DEPTH(DEPTH), .SAMPLE_DELAY(SD), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RST(RST), .KB_CLK(KB_CLK), .KB_DATA(KB_DATA), .RD(RD), .ERR_CLR(ERR_CLR),
        .DOUT(DOUT), .EMPTY(EMPTY), .FULL(FULL), .COUNT(COUNT),
        .PERR(PERR), .FERR(FERR), .OVF(OVF), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of stored bytes and sticky flags
    logic [7:0] mq[$];
    logic       m_perr = 1'b0, m_ferr = 1'b0, m_ovf = 1'b0;
    logic       mvalid = 1'b0;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic oddpar(input logic [7:0] d);
        return ~(^d);
    endfunction

    // Per-cycle comparison against the model whenever no frame is in flight
    always @(negedge CLK) begin
        if (mvalid) begin
            logic [7:0] e_dout;
            logic [2:0] e_cnt;
            e_cnt  = 3'(mq.size());
            e_dout = (mq.size() != 0) ? mq[0] : 8'h00;
            checks++;
            if (DOUT !== e_dout || COUNT !== e_cnt || EMPTY !== (e_cnt == 3'd0) ||
                FULL !== (e_cnt == 3'(DEPTH)) || PERR !== m_perr || FERR !== m_ferr ||
                OVF !== m_ovf || BUSY !== 1'b0) begin
                errors++;
                if (errors < 20)
                    $display("FAIL model_cmp t=%0t dout=%h/%h cnt=%0d/%0d pfo=%b%b%b/%b%b%b busy=%b/0",
                             $time, DOUT, e_dout, COUNT, e_cnt, PERR, FERR, OVF,
                             m_perr, m_ferr, m_ovf, BUSY);
            end
        end
    end

    task automatic rd_pulse();
        RD = 1'b1;
        tick(1);
        RD = 1'b0;
        if (mq.size() != 0) void'(mq.pop_front());
    endtask

    task automatic err_clr();
        ERR_CLR = 1'b1;
        tick(1);
        ERR_CLR = 1'b0;
        m_perr = 1'b0;
        m_ferr = 1'b0;
        m_ovf  = 1'b0;
    endtask

    // Bit-bang one frame; optional glitch after bit glitch_bit, abort before bit abort_bit,
    // or an RD strobe placed on the FIFO push cycle of this frame
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input int glitch_bit, input int abort_bit, input logic rd_push);
        logic [10:0] bits;
        logic        good;
        bits   = {stop, par, d, 1'b0};
        mvalid = 1'b0;
        for (int i = 0; i < 11; i++) begin
            if (i == abort_bit) return;
            KB_DATA = bits[i];
            tick(HALF);
            KB_CLK = 1'b0;
            if (i == 10 && rd_push) begin
                tick(SS + 1 + SD);
                RD = 1'b1;
                tick(1);
                RD = 1'b0;
                tick(HALF - SS - 2 - SD);
            end else begin
                tick(HALF);
            end
            KB_CLK = 1'b1;
            if (i == glitch_bit) begin
                tick(10);
                KB_CLK = 1'b0;
                tick(SD - 2);
                KB_CLK = 1'b1;
                tick(HALF);
            end
        end
        KB_DATA = 1'b1;
        tick(10);
        if (!stop) m_ferr = 1'b1;
        if (par != oddpar(d)) m_perr = 1'b1;
        good = stop && (par == oddpar(d));
        if (rd_push && mq.size() != 0) void'(mq.pop_front());
        if (good) begin
            if (mq.size() == DEPTH) m_ovf = 1'b1;
            else mq.push_back(d);
        end
        mvalid = 1'b1;
    endtask

    task automatic good_frame(input logic [7:0] d);
        send_frame(d, oddpar(d), 1'b1, -1, -1, 1'b0);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int nrd;
        logic [7:0] d;
        logic pb, sb, rp;

        // reset values
        tick(3);
        chk("rst_empty", 32'(EMPTY), 32'd1);
        chk("rst_full", 32'(FULL), 32'd0);
        chk("rst_count", 32'(COUNT), 32'd0);
        chk("rst_dout", 32'(DOUT), 32'h00);
        chk("rst_flags", 32'({PERR, FERR, OVF, BUSY}), 32'd0);
        RST = 1'b1;
        tick(2);
        mvalid = 1'b1;

        // basic frame 0x1C, parity 0
        send_frame(8'h1C, 1'b0, 1'b1, -1, -1, 1'b0);
        chk("f1c_dout", 32'(DOUT), 32'h1C);
        chk("f1c_count", 32'(COUNT), 32'd1);
        chk("f1c_empty", 32'(EMPTY), 32'd0);
        rd_pulse();
        chk("f1c_pop_empty", 32'(EMPTY), 32'd1);
        chk("f1c_pop_dout", 32'(DOUT), 32'h00);

        // parity error, clear, framing error
        send_frame(8'h1C, 1'b1, 1'b1, -1, -1, 1'b0);
        chk("perr_set", 32'(PERR), 32'd1);
        chk("perr_count", 32'(COUNT), 32'd0);
        err_clr();
        chk("perr_clr", 32'(PERR), 32'd0);
        send_frame(8'hF0, 1'b1, 1'b0, -1, -1, 1'b0);
        chk("ferr_set", 32'(FERR), 32'd1);
        chk("ferr_count", 32'(COUNT), 32'd0);
        err_clr();

        // overflow: DEPTH+1 frames
        for (int v = 1; v <= 5; v++) good_frame(8'(v));
        chk("ovf_full", 32'(FULL), 32'd1);
        chk("ovf_flag", 32'(OVF), 32'd1);
        chk("ovf_count", 32'(COUNT), 32'd4);
        for (int k = 1; k <= 4; k++) begin
            chk("ovf_order", 32'(DOUT), 32'(k));
            rd_pulse();
        end
        err_clr();

        // push and pop together while full
        for (int v = 10; v <= 13; v++) good_frame(8'(v));
        send_frame(8'h06, oddpar(8'h06), 1'b1, -1, -1, 1'b1);
        chk("pp_count", 32'(COUNT), 32'd4);
        chk("pp_ovf", 32'(OVF), 32'd0);
        chk("pp_head", 32'(DOUT), 32'h0B);
        repeat (3) rd_pulse();
        chk("pp_last", 32'(DOUT), 32'h06);
        rd_pulse();

        // short low glitch mid-frame
        send_frame(8'h5A, oddpar(8'h5A), 1'b1, 4, -1, 1'b0);
        chk("glitch_dout", 32'(DOUT), 32'h5A);
        chk("glitch_count", 32'(COUNT), 32'd1);
        rd_pulse();

        // reset after 4 data bits
        send_frame(8'h33, oddpar(8'h33), 1'b1, -1, 5, 1'b0);
        chk("mid_busy", 32'(BUSY), 32'd1);
        RST = 1'b0;
        mq.delete();
        m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
        tick(2);
        chk("mid_rst_busy", 32'(BUSY), 32'd0);
        chk("mid_rst_empty", 32'(EMPTY), 32'd1);
        RST = 1'b1;
        tick(2);
        mvalid = 1'b1;
        good_frame(8'h21);
        chk("after_rst_dout", 32'(DOUT), 32'h21);
        rd_pulse();

`ifdef PS2_RX_TIMEOUT_EN
        begin
            int n;
            send_frame(8'h29, oddpar(8'h29), 1'b1, -1, 4, 1'b0);
            n = 0;
            while (BUSY && n < TO + 200) begin
                tick(1);
                n++;
            end
            chk("to_busy", 32'(BUSY), 32'd0);
            chk("to_window", 32'(n >= TO - HALF && n <= TO + 20), 32'd1);
            chk("to_ferr", 32'(FERR), 32'd1);
            m_ferr = 1'b1;
            KB_DATA = 1'b1;
            tick(2);
            mvalid = 1'b1;
            good_frame(8'h29);
            chk("to_next", 32'(DOUT), 32'h29);
            rd_pulse();
            err_clr();
        end
`endif

        // randomized traffic
        for (int it = 0; it < 25; it++) begin
            d  = 8'($urandom);
            pb = ($urandom_range(0, 4) == 0) ? ~oddpar(d) : oddpar(d);
            sb = ($urandom_range(0, 5) != 0);
            rp = ($urandom_range(0, 3) == 0);
            send_frame(d, pb, sb, -1, -1, rp);
            nrd = int'($urandom_range(0, 2));
            for (int r = 0; r < nrd; r++) rd_pulse();
            if ($urandom_range(0, 3) == 0) err_clr();
        end
        tick(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
